// File: rtl/interferometer_pkg.sv
// Shared definitions for the interferometer readout path: FSM state type,
// default frame header and helpers that derive the frame geometry.
package interferometer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_SEQ,
    ST_DATA,
    ST_CSUM
  } readout_state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

  // Number of distinct input pairs correlated by the bank.
  function automatic int num_correlators(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Payload bytes in one frame: every count word (single inputs plus pairs),
  // each res bits wide. Header, sequence and checksum bytes are not included.
  function automatic int frame_bytes(input int res, input int n);
    return (n + num_correlators(n)) * res / 8;
  endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Shadow copy of the counter bank plus a byte selector. The snapshot is taken
// on capture and held for the whole frame; byte i of the frame is bits
// [8*i +: 8], which gives word 0 first and each word least-significant byte first.
module frame_byte_mux
  import interferometer_pkg::*;
#(
  parameter int RESOLUTION = 16,
  parameter int WORDS      = 36,
  localparam int DATA_BYTES = WORDS * RESOLUTION / 8,
  localparam int IDX_W      = $clog2(DATA_BYTES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture,
  input  logic [RESOLUTION*WORDS-1:0] frame_data,
  input  logic [IDX_W-1:0]            byte_index,
  output logic [7:0]                  byte_data
);

  logic [RESOLUTION*WORDS-1:0] shadow;

  // Snapshot the counts when a frame is accepted; hold them otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= frame_data;
    end
  end

  // Pick the current byte out of the snapshot.
  always_comb begin
    byte_data = shadow[{byte_index, 3'b000} +: 8];
  end

endmodule

// File: rtl/correlator_readout_scheduler.sv
// Readout scheduler for the correlator/counter bank. Each accepted integration
// strobe snapshots the counts, pulses clear_counters and streams the frame
// A5 5A <seq> <data bytes> [<xor checksum>] over a valid/ready byte handshake.
// Optional checksum byte: define READOUT_CHECKSUM_EN.
module correlator_readout_scheduler
  import interferometer_pkg::*;
#(
  parameter int          RESOLUTION = 16,
  parameter int          NUM_INPUTS = 8,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
  localparam int NUM_CORRELATORS = num_correlators(NUM_INPUTS),
  localparam int WORDS           = NUM_INPUTS + NUM_CORRELATORS,
  localparam int DATA_BYTES      = frame_bytes(RESOLUTION, NUM_INPUTS),
  localparam int IDX_W           = $clog2(DATA_BYTES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        frame_strobe,
  input  logic [RESOLUTION*WORDS-1:0] frame_data,
  output logic                        clear_counters,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        overrun,
  output logic [7:0]                  frame_count
);

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DATA_BYTES - 1);

  readout_state_t   state;
  readout_state_t   next_state;
  logic [IDX_W-1:0] byte_index;
  logic [7:0]       mux_byte;
  logic             strobe_taken;
  logic             capture;
  logic             drop;
  logic             transfer;
  logic             last_byte;

  assign strobe_taken = frame_strobe & enable;
  assign capture      = strobe_taken & (state == ST_IDLE);
  assign drop         = strobe_taken & (state != ST_IDLE);
  assign transfer     = tx_valid & tx_ready;
  assign last_byte    = (byte_index == LAST_INDEX);
  assign busy         = (state != ST_IDLE);

  frame_byte_mux #(
    .RESOLUTION(RESOLUTION),
    .WORDS     (WORDS)
  ) u_mux (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .frame_data(frame_data),
    .byte_index(byte_index),
    .byte_data (mux_byte)
  );

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of the payload bytes, restarted for every captured frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (capture) begin
      csum <= '0;
    end else if ((state == ST_DATA) && transfer) begin
      csum <= csum ^ mux_byte;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and the byte presented to the UART; outputs depend only on
  // registered state, so tx_data cannot move while a byte is stalled.
  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (capture) next_state = ST_HDR0;
      end
      ST_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_WORD[15:8];
        if (tx_ready) next_state = ST_HDR1;
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_WORD[7:0];
        if (tx_ready) next_state = ST_SEQ;
      end
      ST_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = frame_count;
        if (tx_ready) next_state = ST_DATA;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = mux_byte;
        if (tx_ready && last_byte) begin
`ifdef READOUT_CHECKSUM_EN
          next_state = ST_CSUM;
`else
          next_state = ST_IDLE;
`endif
        end
      end
`ifdef READOUT_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) next_state = ST_IDLE;
      end
`endif
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Side pulses, sequence number and payload byte pointer. Any enabled strobe
  // restarts the integration window, even one that is dropped as an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_counters <= 1'b0;
      overrun        <= 1'b0;
      frame_count    <= '0;
      byte_index     <= '0;
    end else begin
      clear_counters <= strobe_taken;
      overrun        <= drop;
      if (capture) begin
        frame_count <= frame_count + 8'd1;
        byte_index  <= '0;
      end else if ((state == ST_DATA) && transfer) begin
        byte_index <= last_byte ? '0 : byte_index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_correlator_readout_scheduler.sv
// Self-checking bench for correlator_readout_scheduler. Frames are predicted
// from the count words by a byte-list model and compared byte for byte.
`timescale 1ns/1ps
module tb_correlator_readout_scheduler;

  localparam int RES        = 16;
  localparam int NI         = 8;
  localparam int WORDS      = NI + NI * (NI - 1) / 2;
  localparam int DATA_BYTES = WORDS * RES / 8;
`ifdef READOUT_CHECKSUM_EN
  localparam int FRAME_LEN = 3 + DATA_BYTES + 1;
`else
  localparam int FRAME_LEN = 3 + DATA_BYTES;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b1;
  logic                  frame_strobe = 1'b0;
  logic                  tx_ready = 1'b1;
  logic [RES*WORDS-1:0]  frame_data = '0;
  logic                  clear_counters;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  busy;
  logic                  overrun;
  logic [7:0]            frame_count;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         ready_mode = 0;
  int         stall_errs = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         clear_cycles[$];
  int         overrun_cycles[$];
  logic [15:0] words[WORDS];
  logic [7:0] model_count = 8'd0;

  typedef struct {
    logic       en;
    logic       str;
    logic       exp_valid;
    logic       exp_clear;
    logic       exp_overrun;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  correlator_readout_scheduler #(
    .RESOLUTION(RES),
    .NUM_INPUTS(NI)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .frame_strobe  (frame_strobe),
    .frame_data    (frame_data),
    .clear_counters(clear_counters),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready pattern driven just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Receiver-side monitor sampling on the falling edge.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_reset;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_reset = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_reset) begin
        if (!tx_valid || tx_data != prev_data) stall_errs++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_reset = reset;
      if (tx_valid && tx_ready && !reset) got_q.push_back(tx_data);
      if (clear_counters) clear_cycles.push_back(cyc);
      if (overrun) overrun_cycles.push_back(cyc);
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_strobe = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_count = 8'd0;
  endtask

  // kind 0: 0x0100+k, 1: all 0x00FF, 2: word0=1 others 0, else random.
  task automatic load_words(input int kind);
    for (int k = 0; k < WORDS; k++) begin
      case (kind)
        0: words[k] = 16'h0100 + k[15:0];
        1: words[k] = 16'h00FF;
        2: words[k] = (k == 0) ? 16'h0001 : 16'h0000;
        default: words[k] = 16'($urandom);
      endcase
      frame_data[k*RES +: RES] = words[k];
    end
  endtask

  // Expected wire bytes for the words currently held in the model.
  task automatic build_expected(input logic [7:0] seq);
    logic [7:0] x;
    logic [7:0] b8;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(seq);
    for (int k = 0; k < WORDS; k++) begin
      for (int b = 0; b < RES / 8; b++) begin
        b8 = words[k][8*b +: 8];
        exp_q.push_back(b8);
        x = x ^ b8;
      end
    end
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic apply_stimulus(output int at);
    frame_strobe = 1'b1;
    at = cyc;
    tick();
    frame_strobe = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int i;
    i = 0;
    while (got_q.size() < n && i < 1000) begin
      tick();
      i++;
    end
    check_output({name, "_reach"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 1000) begin
      tick();
      i++;
    end
    check_output({name, "_idle"}, 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic compare_frame(input string name);
    int bad;
    int first;
    int n;
    bad = 0;
    first = -1;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check_output({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    if (bad != 0)
      $display("[TB] %s first differing byte %0d got=%0h want=%0h", name, first, got_q[first], exp_q[first]);
    check_output({name, "_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  // Capture one frame of the current words and check it end to end.
  task automatic run_frame(input string name);
    int at;
    model_count = model_count + 8'd1;
    build_expected(model_count);
    got_q.delete();
    clear_cycles.delete();
    overrun_cycles.delete();
    apply_stimulus(at);
    wait_idle(name);
    compare_frame(name);
    check_output({name, "_count"}, 32'(frame_count), 32'(model_count));
  endtask

  initial begin
    vec_t vecs[6];
    int   at;
    int   at2;

    vecs[0] = '{en:1'b0, str:1'b0, exp_valid:1'b0, exp_clear:1'b0, exp_overrun:1'b0, exp_data:8'h00, exp_busy:1'b0};
    vecs[1] = '{en:1'b0, str:1'b1, exp_valid:1'b0, exp_clear:1'b0, exp_overrun:1'b0, exp_data:8'h00, exp_busy:1'b0};
    vecs[2] = '{en:1'b1, str:1'b0, exp_valid:1'b0, exp_clear:1'b0, exp_overrun:1'b0, exp_data:8'h00, exp_busy:1'b0};
    vecs[3] = '{en:1'b1, str:1'b1, exp_valid:1'b1, exp_clear:1'b1, exp_overrun:1'b0, exp_data:8'hA5, exp_busy:1'b1};
    vecs[4] = '{en:1'b0, str:1'b1, exp_valid:1'b0, exp_clear:1'b0, exp_overrun:1'b0, exp_data:8'h00, exp_busy:1'b0};
    vecs[5] = '{en:1'b1, str:1'b1, exp_valid:1'b1, exp_clear:1'b1, exp_overrun:1'b0, exp_data:8'hA5, exp_busy:1'b1};

    load_words(0);
    do_reset();
    check_output("rst_valid", 32'(tx_valid), 32'd0);
    check_output("rst_clear", 32'(clear_counters), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_count", 32'(frame_count), 32'd0);
    check_output("rst_data", 32'(tx_data), 32'd0);

    // Single-cycle response from IDLE for each enable/strobe combination.
    ready_mode = 0;
    for (int v = 0; v < 6; v++) begin
      enable = vecs[v].en;
      frame_strobe = vecs[v].str;
      tick();
      frame_strobe = 1'b0;
      enable = 1'b1;
      if (vecs[v].en && vecs[v].str) model_count = model_count + 8'd1;
      check_output($sformatf("vec%0d_valid", v), 32'(tx_valid), 32'(vecs[v].exp_valid));
      check_output($sformatf("vec%0d_clear", v), 32'(clear_counters), 32'(vecs[v].exp_clear));
      check_output($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_overrun));
      check_output($sformatf("vec%0d_data", v), 32'(tx_data), 32'(vecs[v].exp_data));
      check_output($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      check_output($sformatf("vec%0d_count", v), 32'(frame_count), 32'(model_count));
      if (vecs[v].exp_valid) wait_idle($sformatf("vec%0d", v));
      tick();
    end

    // Reference frame with a clear pulse one cycle after the strobe.
    do_reset();
    load_words(0);
    model_count = 8'd1;
    build_expected(model_count);
    got_q.delete();
    clear_cycles.delete();
    apply_stimulus(at);
    wait_idle("ref");
    compare_frame("ref");
    check_output("ref_len_total", 32'(got_q.size()), 32'(FRAME_LEN));
    check_output("ref_clear_n", 32'(clear_cycles.size()), 32'd1);
    check_output("ref_clear_cyc", 32'((clear_cycles.size() > 0) ? clear_cycles[0] : -1), 32'(at + 1));

    // Same payload with the receiver stalling every other cycle.
    stall_errs = 0;
    ready_mode = 1;
    run_frame("toggle");
    check_output("toggle_stall_stable", 32'(stall_errs), 32'd0);
    ready_mode = 0;

    // Strobe during a frame: dropped, flagged, and the frame is untouched.
    load_words(0);
    model_count = model_count + 8'd1;
    build_expected(model_count);
    got_q.delete();
    clear_cycles.delete();
    overrun_cycles.delete();
    apply_stimulus(at);
    wait_bytes(10, "ovr");
    load_words(3);
    apply_stimulus(at2);
    tick();
    check_output("ovr_n", 32'(overrun_cycles.size()), 32'd1);
    check_output("ovr_cyc", 32'((overrun_cycles.size() > 0) ? overrun_cycles[0] : -1), 32'(at2 + 1));
    check_output("ovr_clear_n", 32'(clear_cycles.size()), 32'd2);
    check_output("ovr_clear_cyc", 32'((clear_cycles.size() > 1) ? clear_cycles[1] : -1), 32'(at2 + 1));
    check_output("ovr_count", 32'(frame_count), 32'(model_count));
    wait_idle("ovr");
    compare_frame("ovr");

    // Randomised payloads and receiver behaviour.
    stall_errs = 0;
    for (int r = 0; r < 8; r++) begin
      ready_mode = $urandom_range(0, 2);
      load_words(3);
      run_frame($sformatf("rand%0d", r));
    end
    check_output("rand_stall_stable", 32'(stall_errs), 32'd0);
    ready_mode = 0;

`ifdef READOUT_CHECKSUM_EN
    load_words(1);
    run_frame("csum_ff");
    check_output("csum_ff_last", 32'((got_q.size() == FRAME_LEN) ? got_q[FRAME_LEN-1] : 9'h100), 32'h00);
    load_words(2);
    run_frame("csum_01");
    check_output("csum_01_last", 32'((got_q.size() == FRAME_LEN) ? got_q[FRAME_LEN-1] : 9'h100), 32'h01);
`endif

    // Reset in the middle of a frame abandons it; the next one starts at seq 1.
    load_words(3);
    got_q.delete();
    apply_stimulus(at);
    wait_bytes(40, "midrst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("midrst_valid", 32'(tx_valid), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_count", 32'(frame_count), 32'd0);
    model_count = 8'd0;
    tick();
    load_words(0);
    run_frame("after_rst");

    // 256 frames from reset bring the sequence number back round to zero.
    do_reset();
    load_words(0);
    for (int f = 0; f < 256; f++) begin
      model_count = model_count + 8'd1;
      got_q.delete();
      apply_stimulus(at);
      wait_idle($sformatf("wrap%0d", f));
    end
    build_expected(model_count);
    compare_frame("wrap_last");
    check_output("wrap_seq", 32'((got_q.size() > 2) ? got_q[2] : 9'h100), 32'h00);
    check_output("wrap_count", 32'(frame_count), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/correlator_readout_scheduler.md
Name: correlator_readout_scheduler

Overview:
- Sequences readout of the correlator/counter bank: on each integration pulse, snapshots all count words, requests a one-cycle counter clear, and streams the frame as bytes to the UART transmitter over a valid/ready handshake.
- Sits between the integration clock generator, the pulse_counter array and the UART TX byte path.
- Replaces the ad-hoc negedge capture with a single-clock scheduled, framed readout.

Parameters:
- RESOLUTION, 16, bits per count word; must be a multiple of 8.
- NUM_INPUTS, 8, ADC inputs. Derived localparams: NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2 = 28; WORDS = NUM_INPUTS+NUM_CORRELATORS = 36; DATA_BYTES = WORDS*RESOLUTION/8 = 72.
- SYNC_WORD, 16'hA55A, frame header.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  readout enable (transmit_enable).
- frame_strobe  in  1  one-cycle integration pulse.
- frame_data  in  RESOLUTION*WORDS  packed counts; word k at [k*RESOLUTION+:RESOLUTION].
- clear_counters  out  1  one-cycle clear to the pulse_counter array.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  UART TX can accept a byte.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  one-cycle pulse when a strobe is dropped.
- frame_count  out  8  sequence number of the last captured frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: state IDLE, and all outputs 0. This includes tx_valid, clear_counters, overrun, frame_count and busy. The shadow register is also cleared to 0.
- States:
  - IDLE: on frame_strobe & enable, capture frame_data into the shadow register, increment frame_count (8-bit, wraps 255->0), go to HDR0.
  - HDR0: emit SYNC_WORD[15:8]; on transfer, go to HDR1.
  - HDR1: emit SYNC_WORD[7:0]; on transfer, go to SEQ.
  - SEQ: emit frame_count; on transfer, go to DATA.
  - DATA: emit data bytes; after the last data byte transfers, go to CSUM (if enabled) or IDLE.
  - CSUM: emit checksum byte; on transfer, go to IDLE.
- Transfer rule: a byte transfers when tx_valid & tx_ready. tx_valid=1 in every non-IDLE state.
- While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid never drops without a transfer, except on reset.
- Data order: word 0 first, each word least-significant byte first. The byte index counter runs 0..DATA_BYTES-1.
- Latency: strobe sampled in cycle N while IDLE → tx_valid=1 with the first header byte in cycle N+1. clear_counters=1 in cycle N+1 only.
- Strobe while not IDLE, with enable=1: frame dropped; shadow and frame_count unchanged; overrun=1 and clear_counters=1 in the next cycle. The integration window still restarts.
- Strobe arriving in the same cycle as the final byte transfer: treated as not IDLE and dropped.
- enable=0: strobes are ignored entirely (no capture, clear or overrun). A frame already in progress completes.
- Reset mid-frame: tx_valid is 0 from the next cycle; the partial frame is abandoned and the state returns to IDLE.
- Wire-level frame length: 3+DATA_BYTES bytes, plus 1 with the checksum option (75/76 at defaults).

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined: a CSUM state appends one byte equal to the XOR of all data bytes (header and sequence excluded). The accumulator is cleared on capture and updated on each data-byte transfer.
- Undefined: no CSUM state and no accumulator logic; DATA goes straight to IDLE.

Decomposition:
- Shared package interferometer_pkg holds:
  - state enum typedef readout_state_t;
  - SYNC_WORD default;
  - constant functions num_correlators(n) and frame_bytes(res, n).
- Sub-module frame_byte_mux: shadow register plus byte-index to byte select. It is combinational select over registered storage; the FSM stays in the top module.

Test Plan:
- Reset then strobe with enable=1, tx_ready=1, word k = 16'h0100+k:
  - clear_counters pulses once in cycle N+1;
  - bytes are A5, 5A, 01, 00, 01, 01, 01, ..., 23, 01; 75 bytes total.
- Same frame with tx_ready toggling every other cycle → identical byte sequence; tx_data stable while stalled; no byte lost or duplicated.
- Second strobe at byte 10 of a frame → overrun=1 and clear_counters=1 one cycle later; frame_count stays 1; the current frame completes unchanged.
- enable=0 with strobe → no tx_valid, clear_counters, overrun or frame_count change. 256 enabled frames → frame_count wraps to 0.
- reset asserted at byte 40 → tx_valid=0 and busy=0 next cycle; the next strobe emits a full frame with sequence byte 01.
- READOUT_CHECKSUM_EN defined, all words 16'h00FF → 76th byte = 8'h00. With word 0 = 16'h0001 and all other words 0 → checksum 8'h01.
